// File: rtl/wr_ctrl_pkg.sv
// Shared types and length helpers for the packet burst writer.
package wr_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, PLAN, BURST, DONE} state_t;

    function automatic logic [31:0] words_of(input logic [31:0] len, input int unsigned bytes);
        return (len + bytes - 1) / bytes;
    endfunction

    // Lane mask for the final word; a whole final word gets every lane.
    function automatic logic [63:0] last_be(input logic [31:0] len, input int unsigned bytes);
        logic [31:0] r;
        r = len % bytes;
        if (r == 0) return (64'd1 << bytes) - 64'd1;
        return (64'd1 << r) - 64'd1;
    endfunction

endpackage

// File: rtl/wr_burst_ctrl_if.sv
// Avalon-MM burst write bus between the writer (master) and the memory slave.
interface wr_burst_ctrl_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16
);
    localparam int BC_W = $clog2(MAX_BURST) + 1;

    logic [ADDR_W-1:0]   avm_address;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_write;
    logic [BC_W-1:0]     avm_burstcount;
    logic                avm_waitrequest;

    modport master (
        output avm_address, avm_writedata, avm_byteenable, avm_write, avm_burstcount,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_writedata, avm_byteenable, avm_write, avm_burstcount,
        output avm_waitrequest
    );
endinterface

// File: rtl/wr_burst_planner.sv
// Sizes the next burst from the words still to write; results register on load and hold for the burst.
// One-cycle latency from load; no backpressure of its own.
module wr_burst_planner #(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16,
    parameter int BYTES     = 4,
    parameter int BC_W      = $clog2(MAX_BURST) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LEN_W-1:0]  remaining,
    input  logic [ADDR_W-1:0] cur_addr,
    output logic [BC_W-1:0]   blen_q,
    output logic [ADDR_W-1:0] addr_q,
    output logic [ADDR_W-1:0] next_addr_q,
    output logic              last_q
);
    logic [BC_W-1:0]   blen;
    logic [ADDR_W-1:0] next_addr;
    logic              last;

    always_comb begin
        blen      = (remaining >= LEN_W'(MAX_BURST)) ? BC_W'(MAX_BURST) : BC_W'(remaining);
        next_addr = cur_addr + (ADDR_W'(blen) * ADDR_W'(BYTES));
        last      = (remaining <= LEN_W'(MAX_BURST));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            blen_q      <= '0;
            addr_q      <= '0;
            next_addr_q <= '0;
            last_q      <= 1'b0;
        end else if (load) begin
            blen_q      <= blen;
            addr_q      <= cur_addr;
            next_addr_q <= next_addr;
            last_q      <= last;
        end
    end
endmodule

// File: rtl/wr_burst_ctrl.sv
// FIFO-to-Avalon-MM burst writer: drains one packet to [pkt_begin, pkt_end), first write 2 cycles after start.
// Stalls on avm_waitrequest or an empty FIFO without reissuing the address. Option macro: WR_BURST_ALIGN_CHECK_EN.
module wr_burst_ctrl
    import wr_ctrl_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] pkt_begin,
    input  logic [ADDR_W-1:0] pkt_end,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [DATA_W-1:0] fifo_rdata,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    wr_burst_ctrl_if.master   avm
);
    localparam int BYTES = DATA_W / 8;
    localparam int BC_W  = $clog2(MAX_BURST) + 1;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cur_addr, burst_addr, next_addr_q;
    logic [LEN_W-1:0]    len_q, remaining, len_in;
    logic [BC_W-1:0]     beat, blen_q;
    logic                last_q, last_beat, final_word;
    logic                bad_req, plan_load, accept, burst_end, wr;
    logic [DATA_W-1:0]   wdata;
    logic [BYTES-1:0]    be, last_mask;

    assign len_in     = LEN_W'(pkt_end - pkt_begin);
    assign last_beat  = (beat == blen_q - BC_W'(1));
    assign final_word = last_q && last_beat;
    assign last_mask  = BYTES'(last_be(32'(len_q), BYTES));

`ifdef WR_BURST_ALIGN_CHECK_EN
    assign bad_req = ((pkt_begin & ADDR_W'(BYTES - 1)) != '0) || (pkt_end < pkt_begin);

    always_ff @(posedge clk) begin
        if (!reset) err <= 1'b0;
        else        err <= (state == IDLE) && start && bad_req;
    end
`else
    assign bad_req = 1'b0;
    assign err     = 1'b0;
`endif

    wr_burst_planner #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST), .BYTES(BYTES)
    ) u_planner (
        .clk(clk), .reset(reset), .load(plan_load), .remaining(remaining), .cur_addr(cur_addr),
        .blen_q(blen_q), .addr_q(burst_addr), .next_addr_q(next_addr_q), .last_q(last_q)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        plan_load = 1'b0;
        wr        = 1'b0;
        wdata     = '0;
        be        = '0;
        accept    = 1'b0;
        burst_end = 1'b0;
        fifo_rd   = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = bad_req ? DONE : PLAN;
            PLAN: begin
                if (remaining == '0) begin
                    state_nxt = DONE;
                end else begin
                    plan_load = 1'b1;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                // Head word is presented directly; without a pop it stays put across stalls.
                wr        = !fifo_empty;
                wdata     = fifo_rdata;
                be        = final_word ? last_mask : '1;
                accept    = wr && !avm.avm_waitrequest;
                fifo_rd   = accept;
                burst_end = accept && last_beat;
                if (burst_end) state_nxt = PLAN;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_addr  <= '0;
            len_q     <= '0;
            remaining <= '0;
            beat      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                cur_addr  <= pkt_begin & ~ADDR_W'(BYTES - 1);
                len_q     <= len_in;
                remaining <= LEN_W'(words_of(32'(len_in), BYTES));
                beat      <= '0;
                busy      <= 1'b1;
            end
            if (accept) begin
                remaining <= remaining - LEN_W'(1);
                beat      <= burst_end ? '0 : beat + BC_W'(1);
            end
            if (burst_end) cur_addr <= next_addr_q;
            if (state == DONE) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

    assign avm.avm_address    = burst_addr;
    assign avm.avm_burstcount = blen_q;
    assign avm.avm_write      = wr;
    assign avm.avm_writedata  = wdata;
    assign avm.avm_byteenable = be;
endmodule

// File: tb/tb_wr_burst_ctrl.sv
// Directed and randomized checks of wr_burst_ctrl against a word/burst arithmetic model.
module tb_wr_burst_ctrl;
    localparam int DATA_W = 32, ADDR_W = 32, MAX_BURST = 16, LEN_W = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pkt_begin = '0, pkt_end = '0;
    logic        busy, done, err, fifo_empty, fifo_rd;
    logic [31:0] fifo_rdata;

    wr_burst_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) bus ();

    wr_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .pkt_begin(pkt_begin), .pkt_end(pkt_end),
        .busy(busy), .done(done), .err(err), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
        .fifo_rd(fifo_rd), .avm(bus)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model
    logic [31:0] fifo_mem [0:1023];
    int wr_ptr = 0, rd_ptr = 0;
    assign fifo_rdata = fifo_mem[rd_ptr[9:0]];
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) if (fifo_rd) rd_ptr <= rd_ptr + 1;

    int vectors = 0, miscompares = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0, first_wr_cyc = -1;
    int done_cnt = 0, err_cnt = 0, beats_seen = 0, stall_cnt = 0, gap_cnt = 0, gap_lim = 0;
    bit rand_wait = 0, stall_en = 0;
    logic [31:0] exp_data[$], obs_addr[$], obs_data[$];
    logic [4:0]  obs_bc[$];
    logic [3:0]  obs_be[$];
    logic        pv_stall = 0;
    logic [31:0] pv_data, pv_addr;
    logic [3:0]  pv_be;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rand_wait) bus.avm_waitrequest = ($urandom_range(0, 3) == 0);
        else bus.avm_waitrequest = stall_en && beats_seen >= 2 && beats_seen <= 4 && (cyc % 3 != 0);
    end

    always @(negedge clk) begin
        if (!reset) begin
            pv_stall = 1'b0;
        end else begin
            if (start && !busy) start_cyc = cyc;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) err_cnt++;
            if (bus.avm_write && first_wr_cyc < 0) first_wr_cyc = cyc;
            if (bus.avm_write && bus.avm_waitrequest) stall_cnt++;
            if (busy && !bus.avm_write && beats_seen > 0 && beats_seen < gap_lim) gap_cnt++;
            if (bus.avm_write || fifo_rd) chk("fifo_rd", fifo_rd, bus.avm_write && !bus.avm_waitrequest);
            if (pv_stall) begin
                chk("hold_write", bus.avm_write, 1);
                chk("hold_data", bus.avm_writedata, pv_data);
                chk("hold_be", bus.avm_byteenable, pv_be);
                chk("hold_addr", bus.avm_address, pv_addr);
            end
            if (bus.avm_write && !bus.avm_waitrequest) begin
                obs_addr.push_back(bus.avm_address);
                obs_bc.push_back(bus.avm_burstcount);
                obs_data.push_back(bus.avm_writedata);
                obs_be.push_back(bus.avm_byteenable);
                beats_seen++;
            end
            pv_stall = bus.avm_write && bus.avm_waitrequest;
            pv_data  = bus.avm_writedata;
            pv_be    = bus.avm_byteenable;
            pv_addr  = bus.avm_address;
        end
    end

    task automatic clear_obs();
        obs_addr.delete(); obs_bc.delete(); obs_data.delete(); obs_be.delete(); exp_data.delete();
        done_cnt = 0; err_cnt = 0; beats_seen = 0; stall_cnt = 0; gap_cnt = 0; gap_lim = 0;
        first_wr_cyc = -1;
    endtask

    task automatic push_words(input int n);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            fifo_mem[wr_ptr[9:0]] = d;
            wr_ptr++;
            exp_data.push_back(d);
        end
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [31:0] e);
        @(posedge clk); #1;
        pkt_begin = b; pkt_end = e; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic start_pkt(input logic [31:0] b, input logic [31:0] e);
        pulse_start(b, e);
        @(negedge clk);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt == 0 && t < 3000) begin @(negedge clk); t++; end
        chk("done_seen", done_cnt != 0, 1);
        repeat (4) @(negedge clk);
        chk("busy_idle", busy, 0);
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (beats_seen < n && t < 3000) begin @(posedge clk); t++; end
        chk("beats_reached", beats_seen >= n, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_fifo_rd"}, fifo_rd, 0);
        chk({tag, "_write"}, bus.avm_write, 0);
        chk({tag, "_addr"}, bus.avm_address, 0);
        chk({tag, "_bc"}, bus.avm_burstcount, 0);
        chk({tag, "_be"}, bus.avm_byteenable, 0);
        chk({tag, "_wdata"}, bus.avm_writedata, 0);
    endtask

    // Reference: word i goes to burst i/16 at base + 64*(i/16); last word masked by len % 4.
    task automatic check_pkt(input logic [31:0] b, input logic [31:0] e, input bit bad);
        int unsigned len, words, k, bc;
        logic [3:0] be;
        len   = (e - b) & 32'hFFFF;
        words = bad ? 0 : (len + 3) / 4;
        chk("beats", obs_data.size(), words);
        for (int i = 0; i < int'(words) && i < obs_data.size(); i++) begin
            k  = i / 16;
            bc = (words - k * 16 > 16) ? 16 : words - k * 16;
            be = (i == int'(words) - 1 && (len % 4) != 0) ? 4'((1 << (len % 4)) - 1) : 4'hF;
            chk($sformatf("addr[%0d]", i), obs_addr[i], (b & ~32'h3) + k * 64);
            chk($sformatf("bc[%0d]", i), obs_bc[i], bc);
            chk($sformatf("data[%0d]", i), obs_data[i], exp_data[i]);
            chk($sformatf("be[%0d]", i), obs_be[i], be);
        end
        chk("done_cnt", done_cnt, 1);
        chk("err_cnt", err_cnt, bad ? 1 : 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b, e;
        bit bad;
        bus.avm_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1 reset = 1'b1;

        // single full burst, FIFO pre-filled
        clear_obs(); push_words(16);
        start_pkt(32'h1000, 32'h1040);
        wait_done();
        check_pkt(32'h1000, 32'h1040, 0);
        chk("first_write_latency", first_wr_cyc - start_cyc, 2);

        // three bursts with a partial last word; a start while busy is ignored
        clear_obs(); push_words(34);
        start_pkt(32'h2000, 32'h2086);
        wait_beats(3);
        pulse_start(32'h9000, 32'h9100);
        wait_done();
        check_pkt(32'h2000, 32'h2086, 0);

        // waitrequest stalls around beats 3-5
        clear_obs(); push_words(8); stall_en = 1;
        start_pkt(32'h3000, 32'h3020);
        wait_done();
        stall_en = 0;
        check_pkt(32'h3000, 32'h3020, 0);
        chk("stalls_seen", stall_cnt >= 3, 1);

        // FIFO underrun after 5 of 8 words, refilled 4 cycles later
        clear_obs(); gap_lim = 8; push_words(5);
        start_pkt(32'h4000, 32'h4020);
        wait_beats(5);
        repeat (4) @(posedge clk);
        #1 push_words(3);
        wait_done();
        check_pkt(32'h4000, 32'h4020, 0);
        chk("underrun_gap", gap_cnt, 4);

        // zero-length packet
        clear_obs();
        start_pkt(32'h5000, 32'h5000);
        wait_done();
        check_pkt(32'h5000, 32'h5000, 0);
        chk("zero_len_done_cycle", done_cyc - start_cyc, 3);
        chk("zero_len_no_write", first_wr_cyc, -1);

        // misaligned begin: rejected with the option, masked without it
        clear_obs();
`ifdef WR_BURST_ALIGN_CHECK_EN
        bad = 1;
`else
        bad = 0;
        push_words(16);
`endif
        start_pkt(32'h1002, 32'h1040);
        wait_done();
        check_pkt(32'h1002, 32'h1040, bad);

        // reset mid-burst, then a normal packet
        clear_obs(); push_words(10);
        start_pkt(32'h6000, 32'h6028);
        wait_beats(4);
        #1 reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk_zero("mid_reset");
        @(posedge clk); #1 reset = 1'b1;
        wr_ptr = rd_ptr;
        repeat (5) @(negedge clk);
        chk("no_done_after_reset", done_cnt, 0);
        clear_obs(); push_words(12);
        start_pkt(32'h7000, 32'h7030);
        wait_done();
        check_pkt(32'h7000, 32'h7030, 0);

        // randomized packets with random waitrequest
        rand_wait = 1;
        for (int n = 0; n < 6; n++) begin
            clear_obs();
            b = 32'h8000 + $urandom_range(0, 255) * 4;
`ifndef WR_BURST_ALIGN_CHECK_EN
            b = b + $urandom_range(0, 3);
`endif
            e = b + $urandom_range(1, 200);
            push_words(int'(((e - b) + 3) / 4));
            start_pkt(b, e);
            wait_done();
            check_pkt(b, e, 0);
        end
        rand_wait = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
